filter_seq: RTL



---
 rtl/filter_seq.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/filter_seq.sv
// filter_seq: host-side sequencer for the 12th-order all-pole FILTER block.
// Double-buffers a 12-coefficient frame, shifts it into the filter between
// samples, issues a clear on request, and runs one start/done handshake per
// sample tick, returning each filtered sample with a one-cycle valid strobe.
//
// Ports
//   clk, rst_an        clock, asynchronous active-low reset
//   wr_en/addr/data    staging RAM write (accepted only while wr_ready=1)
//   commit             request transfer of the staging frame to the filter
//   clear_req          request a filter state clear
//   wr_ready           low while a frame is being shifted into the filter
//   sample_tick/src_in sample-rate strobe and excitation sample
//   filt_*             filter host interface (coef/load/clear/sig/start/done/out)
//   sample_out/valid   last filtered sample and its strobe
//   overrun            tick dropped because the previous one was not started yet
//   wd_err             filter did not return done within WD_CYCLES cycles
module filter_seq #(
   parameter int WD_CYCLES = 1023
) (
   input  logic        clk,
   input  logic        rst_an,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [9:0]  wr_data,
   input  logic        commit,
   input  logic        clear_req,
   output logic        wr_ready,
   input  logic        sample_tick,
   input  logic [15:0] src_in,
   output logic [9:0]  filt_coef,
   output logic        filt_coef_load,
   output logic        filt_clear,
   output logic [15:0] filt_sig,
   output logic        filt_start,
   input  logic        filt_done,
   input  logic [15:0] filt_out,
   output logic [15:0] sample_out,
   output logic        sample_valid,
   output logic        overrun,
   output logic        wd_err
);

   localparam int WDW = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLEAR, S_GO, S_WAIT} state_t;

   state_t         state, state_nx;
   logic [9:0]     staging [12];
   logic [3:0]     idx, idx_nx;
   logic [WDW-1:0] wd, wd_nx;
   logic           load_pend, clear_pend, tick_pend;
   logic [15:0]    src_pend;

   logic [9:0]     coef_nx;
   logic [15:0]    sig_nx, sout_nx;
   logic           coef_load_nx, clear_nx, start_nx, ready_nx, svalid_nx, wderr_nx;
   logic           consume, load_done, clr_done;

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      wd_nx        = wd;
      coef_nx      = filt_coef;
      coef_load_nx = 1'b0;
      clear_nx     = 1'b0;
      start_nx     = 1'b0;
      sig_nx       = filt_sig;
      ready_nx     = wr_ready;
      sout_nx      = sample_out;
      svalid_nx    = 1'b0;
      wderr_nx     = 1'b0;
      consume      = 1'b0;
      load_done    = 1'b0;
      clr_done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (filt_done) begin
               if (load_pend) begin
                  // first coefficient goes out on the same edge we enter S_LOAD
                  state_nx     = S_LOAD;
                  idx_nx       = 4'd1;
                  coef_nx      = staging[0];
                  coef_load_nx = 1'b1;
                  ready_nx     = 1'b0;
               end else if (clear_pend) begin
                  state_nx = S_CLEAR;
                  clear_nx = 1'b1;
               end else if (tick_pend) begin
                  state_nx = S_GO;
                  sig_nx   = src_pend;
                  start_nx = 1'b1;
                  consume  = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (idx == 4'd12) begin
               state_nx  = S_IDLE;
               ready_nx  = 1'b1;
               load_done = 1'b1;
            end else begin
               coef_nx      = staging[idx];
               coef_load_nx = 1'b1;
               idx_nx       = idx + 4'd1;
            end
         end
         S_CLEAR: begin
            state_nx = S_IDLE;
            clr_done = 1'b1;
         end
         S_GO: begin
            // filter still shows done while it samples start; skip one cycle
            state_nx = S_WAIT;
            wd_nx    = '0;
         end
         S_WAIT: begin
            if (filt_done) begin
               state_nx  = S_IDLE;
               sout_nx   = filt_out;
               svalid_nx = 1'b1;
            end else if (wd == WDW'(WD_CYCLES - 1)) begin
               state_nx = S_IDLE;
               wderr_nx = 1'b1;
            end else begin
               wd_nx = wd + 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         state          <= S_IDLE;
         idx            <= '0;
         wd             <= '0;
         filt_coef      <= '0;
         filt_coef_load <= 1'b0;
         filt_clear     <= 1'b0;
         filt_start     <= 1'b0;
         filt_sig       <= '0;
         wr_ready       <= 1'b1;
         sample_out     <= '0;
         sample_valid   <= 1'b0;
         wd_err         <= 1'b0;
         overrun        <= 1'b0;
         load_pend      <= 1'b0;
         clear_pend     <= 1'b0;
         tick_pend      <= 1'b0;
         src_pend       <= '0;
         for (int i = 0; i < 12; i++) staging[i] <= '0;
      end else begin
         state          <= state_nx;
         idx            <= idx_nx;
         wd             <= wd_nx;
         filt_coef      <= coef_nx;
         filt_coef_load <= coef_load_nx;
         filt_clear     <= clear_nx;
         filt_start     <= start_nx;
         filt_sig       <= sig_nx;
         wr_ready       <= ready_nx;
         sample_out     <= sout_nx;
         sample_valid   <= svalid_nx;
         wd_err         <= wderr_nx;
         if (wr_en && wr_ready && wr_addr < 4'd12) staging[wr_addr] <= wr_data;
         load_pend  <= (load_pend & ~load_done) | (commit & wr_ready);
         clear_pend <= (clear_pend & ~clr_done) | clear_req;
         // a tick coinciding with the start that consumes the pending one is
         // latched, not dropped
         tick_pend  <= (tick_pend & ~consume) | sample_tick;
         if (sample_tick && (!tick_pend || consume)) src_pend <= src_in;
         overrun    <= sample_tick & tick_pend & ~consume;
      end
   end

endmodule
